// File: rtl/led_sequencer.sv
// Timed LED pattern sequencer: a prescaler produces step ticks and an
// IDLE/RUN/DONE controller walks the selected pattern for STEPS ticks.
module led_sequencer #(
  parameter int TICK_DIV = 50000000,
  parameter int TICK_W   = 26,
  parameter int STEPS    = 8,
  parameter int STEP_W   = 8
) (
  input  logic       mclk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [3:0] Led
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic                DIR_LEFT  = 1'b0;
  localparam logic                DIR_RIGHT = 1'b1;
  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEPS - 1);

  state_t              state_reg, state_next;
  logic [TICK_W-1:0]   presc_reg, presc_next;
  logic [STEP_W-1:0]   step_reg, step_next;
  logic                dir_reg, dir_next;
  logic [1:0]          mode_reg, mode_next;
  logic [3:0]          led_reg, led_next;

  logic                tick;
  logic [3:0]          led_step;
  logic                dir_step;

  function automatic logic [3:0] init_pattern(input logic [1:0] sel);
    case (sel)
      2'b00:   return 4'b0000;
      2'b01:   return 4'b0001;
      2'b10:   return 4'b1111;
      default: return 4'b0001;
    endcase
  endfunction

  assign tick = (presc_reg == TICK_LAST);

  // Successor pattern for the latched mode; pingpong also reports the new direction.
  always_comb begin
    led_step = led_reg;
    dir_step = dir_reg;
    case (mode_reg)
      2'b00: led_step = led_reg + 4'd1;
      2'b01: led_step = {led_reg[2:0], led_reg[3]};
      2'b10: led_step = ~led_reg;
      default: begin
        if (led_reg == 4'b1000) begin
          led_step = 4'b0100;
          dir_step = DIR_RIGHT;
        end else if (led_reg == 4'b0001) begin
          led_step = 4'b0010;
          dir_step = DIR_LEFT;
        end else if (dir_reg == DIR_LEFT) begin
          led_step = {led_reg[2:0], 1'b0};
        end else begin
          led_step = {1'b0, led_reg[3:1]};
        end
      end
    endcase
  end

  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    step_next  = step_reg;
    dir_next   = dir_reg;
    mode_next  = mode_reg;
    led_next   = led_reg;
    case (state_reg)
      IDLE: begin
        // abort outranks a coincident start and blanks the display
        if (abort) begin
          led_next   = 4'b0000;
          presc_next = '0;
          step_next  = '0;
        end else if (start) begin
          state_next = RUN;
          mode_next  = mode;
          presc_next = '0;
          step_next  = '0;
          dir_next   = DIR_LEFT;
          led_next   = init_pattern(mode);
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
          led_next   = 4'b0000;
          presc_next = '0;
          step_next  = '0;
        end else if (tick) begin
          presc_next = '0;
          led_next   = led_step;
          dir_next   = dir_step;
          step_next  = step_reg + STEP_W'(1);
          if (step_reg == STEP_LAST) begin
            state_next = DONE;
          end
        end else begin
          presc_next = presc_reg + TICK_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      presc_reg <= '0;
      step_reg  <= '0;
      dir_reg   <= DIR_LEFT;
      mode_reg  <= 2'b00;
      led_reg   <= 4'b0000;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      step_reg  <= step_next;
      dir_reg   <= dir_next;
      mode_reg  <= mode_next;
      led_reg   <= led_next;
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign Led  = led_reg;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: two instances (STEPS=5 and STEPS=20)
// share stimulus; a pattern-arithmetic model predicts every cycle's outputs.
module tb_led_sequencer;

  localparam int TD = 4;
  localparam int S0 = 5;
  localparam int S1 = 20;

  logic       mclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       busy_a, done_a, busy_b, done_b;
  logic [3:0] led_a, led_b;

  always #5 mclk = ~mclk;

  led_sequencer #(.TICK_DIV(TD), .TICK_W(3), .STEPS(S0), .STEP_W(3)) dut_a (
    .mclk(mclk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
    .busy(busy_a), .done(done_a), .Led(led_a)
  );

  led_sequencer #(.TICK_DIV(TD), .TICK_W(3), .STEPS(S1), .STEP_W(5)) dut_b (
    .mclk(mclk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
    .busy(busy_b), .done(done_b), .Led(led_b)
  );

  typedef struct {
    int         cyc;
    logic       busy;
    logic       done;
    logic [3:0] led;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state per instance
  int         steps_of[2];
  bit         running[2];
  bit         in_done[2];
  int         t_off[2];
  logic [1:0] mq[2];
  logic [3:0] le[2];

  always @(posedge mclk) cyc <= cyc + 1;

  // Pattern after n steps, straight from the pattern definitions.
  function automatic logic [3:0] pat(input logic [1:0] m, input int n);
    case (m)
      2'b00:   return 4'(n % 16);
      2'b01:   return 4'(1 << (n % 4));
      2'b10:   return ((n % 2) == 0) ? 4'hF : 4'h0;
      default: begin
        case (n % 6)
          0:       return 4'b0001;
          1:       return 4'b0010;
          2:       return 4'b0100;
          3:       return 4'b1000;
          4:       return 4'b0100;
          default: return 4'b0010;
        endcase
      end
    endcase
  endfunction

  task automatic check(input string nm, input exp_t e, input logic b, input logic d,
                       input logic [3:0] l);
    checks++;
    if (b !== e.busy || d !== e.done || l !== e.led) begin
      errors++;
      $display("FAIL %s cyc=%0d: got busy=%b done=%b Led=%h, expected busy=%b done=%b Led=%h",
               nm, e.cyc, b, d, l, e.busy, e.done, e.led);
    end else if (d === 1'b1) begin
      $display("txn %s: run complete at cyc %0d, Led=%h", nm, e.cyc, l);
    end
  endtask

  always @(negedge mclk) begin
    exp_t e;
    if (q_a.size() > 0 && q_a[0].cyc <= cyc) begin
      e = q_a.pop_front();
      check("dut_a", e, busy_a, done_a, led_a);
    end
    if (q_b.size() > 0 && q_b[0].cyc <= cyc) begin
      e = q_b.pop_front();
      check("dut_b", e, busy_b, done_b, led_b);
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      running[i] = 1'b0;
      in_done[i] = 1'b0;
      t_off[i]   = 0;
      mq[i]      = 2'b00;
      le[i]      = 4'b0000;
    end
  endtask

  // Drive one cycle of inputs and predict outputs after the next rising edge.
  task automatic drive(input logic s, input logic [1:0] m, input logic a);
    exp_t e;
    start = s;
    mode  = m;
    abort = a;
    for (int i = 0; i < 2; i++) begin
      e.cyc  = cyc + 1;
      e.busy = 1'b0;
      e.done = 1'b0;
      if (in_done[i]) begin
        in_done[i] = 1'b0;
      end else if (running[i]) begin
        t_off[i]++;
        if (a) begin
          running[i] = 1'b0;
          le[i] = 4'b0000;
        end else if (t_off[i] == TD * steps_of[i]) begin
          running[i] = 1'b0;
          in_done[i] = 1'b1;
          e.done = 1'b1;
          le[i] = pat(mq[i], steps_of[i]);
        end else begin
          e.busy = 1'b1;
          le[i] = pat(mq[i], t_off[i] / TD);
        end
      end else if (a) begin
        le[i] = 4'b0000;
      end else if (s) begin
        running[i] = 1'b1;
        t_off[i] = 0;
        mq[i] = m;
        e.busy = 1'b1;
        le[i] = pat(m, 0);
      end
      e.led = le[i];
      if (i == 0) q_a.push_back(e);
      else q_b.push_back(e);
    end
    @(posedge mclk);
    #1;
  endtask

  task automatic check_reset_outputs();
    exp_t z;
    z.cyc = cyc; z.busy = 1'b0; z.done = 1'b0; z.led = 4'b0000;
    check("async_reset_a", z, busy_a, done_a, led_a);
    check("async_reset_b", z, busy_b, done_b, led_b);
  endtask

  initial begin
    int drain;
    steps_of[0] = S0;
    steps_of[1] = S1;
    model_reset();

    // Asynchronous reset takes effect before any clock edge.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    @(negedge mclk);
    @(negedge mclk);
    rst_n = 1'b1;
    @(posedge mclk);
    #1;

    repeat (50) drive(1'b0, 2'($urandom_range(0, 3)), 1'b0);

    // Full runs of every mode; dut_b covers count wrap and both pingpong turns.
    for (int m = 0; m < 4; m++) begin
      drive(1'b1, 2'(m), 1'b0);
      repeat (85) drive(1'b0, 2'($urandom_range(0, 3)), 1'b0);
    end

    // Re-start mid-run ignored, abort on a coincident tick, start+abort in IDLE.
    drive(1'b1, 2'b00, 1'b0);
    repeat (5) drive(1'b0, 2'b00, 1'b0);
    drive(1'b1, 2'b01, 1'b0);
    drive(1'b0, 2'b00, 1'b0);
    drive(1'b0, 2'b00, 1'b1);
    repeat (3) drive(1'b0, 2'b00, 1'b0);
    drive(1'b1, 2'b10, 1'b0);
    repeat (25) drive(1'b0, 2'b00, 1'b0);
    drive(1'b1, 2'b10, 1'b1);
    repeat (3) drive(1'b0, 2'b00, 1'b0);

    // Reset in the middle of a run.
    drive(1'b1, 2'b11, 1'b0);
    repeat (9) drive(1'b0, 2'b00, 1'b0);
    q_a.delete();
    q_b.delete();
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    @(negedge mclk);
    rst_n = 1'b1;
    @(posedge mclk);
    #1;
    repeat (10) drive(1'b0, 2'b00, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 49) == 0));
    end
    drive(1'b0, 2'b00, 1'b0);

    drain = 0;
    while ((q_a.size() > 0 || q_b.size() > 0) && drain < 5) begin
      @(negedge mclk);
      #1;
      drain++;
    end
    if (q_a.size() > 0 || q_b.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expectations left, required 0/0", q_a.size(), q_b.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
